posit_mac_ctrl: RTL

Job sequencer for one posit_mac instance with K-element dot products. On start it streams NUM dot products: reads K weight/data posit pairs per dot product from two 1-cycle-latency read ports, bursts them into the MAC, waits for the rounded posit result, and writes it to a result buffer. It also enforces the idle gap the MAC needs to clear its accumulator, and flags a lost result with a timeout.

---
 rtl/pmac_pkg.sv | 26 ++
 rtl/pmac_ctrl_timer.sv | 27 ++
 rtl/posit_mac_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pmac_pkg.sv
// Shared types and helpers for the posit MAC job sequencer.
// Holds the FSM state encoding, operand address helper and default sizing constants.
package pmac_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_K     = 1;
    localparam int DEF_GAP   = 2;
    localparam int DEF_TO    = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_t;

    // Operand address of element elem of dot product idx; callers truncate to AW.
    function automatic logic [31:0] addr_calc(input logic [31:0] idx,
                                              input logic [31:0] elem,
                                              input logic [31:0] k);
        return idx * k + elem;
    endfunction

endpackage

// File: rtl/pmac_ctrl_timer.sv
// Loadable down-counter shared by the GAP and timeout intervals; zero latency on load.
// last is high in the final cycle of a loaded interval, then the counter parks at 0.
module pmac_ctrl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/posit_mac_ctrl.sv
// Job sequencer for one posit_mac: K-beat bursts per dot product, result write, timeout, GAP idle.
// No backpressure; optional perf counters via PMAC_CTRL_PERF_EN.
module posit_mac_ctrl
    import pmac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int K     = DEF_K,
    parameter int AW    = 10,
    parameter int NW    = 8,
    parameter int GAP   = DEF_GAP,
    parameter int TO    = DEF_TO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    num,
    output logic             busy,
    output logic             done,
    output logic             err_to,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_rdata,
    output logic             d_rd_en,
    output logic [AW-1:0]    d_addr,
    input  logic [WIDTH-1:0] d_rdata,
    output logic             mac_vld_i,
    output logic [WIDTH-1:0] mac_win,
    output logic [WIDTH-1:0] mac_din,
    input  logic             mac_vld_o,
    input  logic [WIDTH-1:0] mac_acc_o,
    output logic             res_we,
    output logic [AW-1:0]    res_addr,
    output logic [WIDTH-1:0] res_wdata
`ifdef PMAC_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_cyc,
    output logic [15:0]      perf_lat
`endif
);

    localparam int EW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = $clog2(((TO > GAP) ? TO : GAP) + 1);

    state_t            state, state_n;
    logic [NW-1:0]     num_q;
    logic [NW-1:0]     idx;
    logic [EW-1:0]     elem;
    logic [WIDTH-1:0]  cap;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_last;
    logic              rd;

    pmac_ctrl_timer #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: if (start) state_n = (num == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (elem == EW'(K - 1)) begin
                    // Timeout window opens on the cycle the last beat reaches the MAC.
                    state_n  = S_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TO);
                end
            end
            S_WAIT: if (mac_vld_o || tmr_last) state_n = S_WRITE;
            S_WRITE: begin
                if (GAP > 0) begin
                    state_n  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP);
                end else begin
                    state_n = (idx + NW'(1) == num_q) ? S_DONE : S_ISSUE;
                end
            end
            S_GAP: if (tmr_last) state_n = (idx == num_q) ? S_DONE : S_ISSUE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            num_q     <= '0;
            idx       <= '0;
            elem      <= '0;
            cap       <= '0;
            err_to    <= 1'b0;
            mac_vld_i <= 1'b0;
        end else begin
            state     <= state_n;
            mac_vld_i <= rd;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q  <= num;
                        idx    <= '0;
                        elem   <= '0;
                        err_to <= 1'b0;
                    end
                end
                S_ISSUE: elem <= (state_n == S_WAIT) ? '0 : elem + EW'(1);
                S_WAIT: begin
                    if (mac_vld_o) begin
                        cap <= mac_acc_o;
                    end else if (tmr_last) begin
                        cap    <= '0;
                        err_to <= 1'b1;
                    end
                end
                S_WRITE: idx <= idx + NW'(1);
                default: ;
            endcase
        end
    end

    assign rd        = (state == S_ISSUE);
    assign busy      = (state == S_ISSUE) || (state == S_WAIT) ||
                       (state == S_WRITE) || (state == S_GAP);
    assign done      = (state == S_DONE);
    assign w_rd_en   = rd;
    assign d_rd_en   = rd;
    assign w_addr    = rd ? AW'(addr_calc(32'(idx), 32'(elem), 32'(K))) : '0;
    assign d_addr    = w_addr;
    // The read ports' output register is the alignment stage; mac_vld_i is rd delayed to match.
    assign mac_win   = mac_vld_i ? w_rdata : '0;
    assign mac_din   = mac_vld_i ? d_rdata : '0;
    assign res_we    = (state == S_WRITE);
    assign res_addr  = res_we ? AW'(idx) : '0;
    assign res_wdata = res_we ? cap : '0;

`ifdef PMAC_CTRL_PERF_EN
    logic [31:0] cyc_cnt;
    logic [15:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            lat_cnt  <= '0;
            perf_cyc <= '0;
            perf_lat <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cyc_cnt  <= '0;
                perf_lat <= '0;
            end else if (busy) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (state == S_DONE) perf_cyc <= cyc_cnt;
            if (state == S_ISSUE && state_n == S_WAIT) begin
                lat_cnt <= '0;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 16'd1;
            end
            if (state == S_WAIT && mac_vld_o && lat_cnt > perf_lat) perf_lat <= lat_cnt;
        end
    end
`endif

endmodule
